// File: rtl/mc_core_pkg.sv
// Shared encodings for the multi-cycle core sequencer.
// Optional watchdog halt is built only with CTRL_TIMEOUT_EN defined.
package mc_core_pkg;

  localparam int FETCH_I  = 0;
  localparam int DECODE_I = 1;
  localparam int EXEC_I   = 2;
  localparam int MEM_I    = 3;
  localparam int WB_I     = 4;
  localparam int HALT_I   = 5;

  typedef enum logic [5:0] {
    S_FETCH  = 6'b000001,
    S_DECODE = 6'b000010,
    S_EXEC   = 6'b000100,
    S_MEM    = 6'b001000,
    S_WB     = 6'b010000,
    S_HALT   = 6'b100000
  } state_t;

  localparam logic [31:0] RESET_PC_DEF = 32'h8000_0000;
  localparam logic [31:0] NOP_INS      = 32'h0000_0013;

  function automatic logic is_wait_state(input state_t s);
    return s[FETCH_I] | s[MEM_I];
  endfunction

endpackage

// File: rtl/mc_req_hold.sv
// Req/ack holder for one memory port, with an optional wait watchdog.
// The watchdog exists only when CTRL_TIMEOUT_EN is defined.
module mc_req_hold #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic ack,
  output logic req_o,
  output logic done_o,
  output logic timeout_o
);

  // Zero-wait ack is legal, so done is combinational.
  assign req_o  = start;
  assign done_o = start & ack;

`ifdef CTRL_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LAST =
    CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt;
  logic          waiting;

  assign waiting = start & ~ack;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (waiting) begin
      cnt <= cnt + 1'b1;
    end else begin
      cnt <= '0;
    end
  end

  // Fires on the last tolerated wait cycle.
  assign timeout_o = waiting & (cnt == LAST);
`else
  logic unused_cfg;
  assign unused_cfg = ^{clk, rst_n, TIMEOUT_CYCLES};
  assign timeout_o  = 1'b0;
`endif

endmodule

// File: rtl/mc_core_ctrl.sv
// Multi-cycle core sequencer: FETCH/DECODE/EXEC/MEM/WB/HALT.
// Build with CTRL_TIMEOUT_EN to enable the wait watchdog.
module mc_core_ctrl
  import mc_core_pkg::*;
#(
  parameter int XLEN = 32,
  parameter logic [XLEN-1:0] RESET_PC =
    XLEN'(RESET_PC_DEF),
  parameter int CNT_W = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic             clk,
  input  logic             i_rst_n,
  output logic             o_ifu_req,
  output logic [XLEN-1:0]  o_ifu_addr,
  input  logic             i_ifu_ack,
  input  logic [31:0]      i_ifu_rdata,
  output logic [31:0]      o_ins,
  input  logic             i_is_load,
  input  logic             i_is_store,
  input  logic             i_is_ebreak,
  input  logic             i_a0_zero,
  input  logic [XLEN-1:0]  i_pc_next,
  output logic [XLEN-1:0]  o_pc,
  output logic             o_lsu_req,
  input  logic             i_lsu_ack,
  input  logic             i_wen,
  input  logic             i_csr_wen,
  output logic             o_rf_wen,
  output logic             o_csr_wen,
  output logic             o_commit,
  output logic [CNT_W-1:0] o_instret,
  output logic             o_halt,
  output logic             o_good_trap,
  output logic             o_timeout
);

  state_t state;
  state_t state_nx;

  logic ifu_start;
  logic ifu_done;
  logic ifu_to;
  logic lsu_start;
  logic lsu_done;
  logic lsu_to;
  logic wd_expire;

  mc_req_hold #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_ifu_hold (
    .clk      (clk),
    .rst_n    (i_rst_n),
    .start    (ifu_start),
    .ack      (i_ifu_ack),
    .req_o    (o_ifu_req),
    .done_o   (ifu_done),
    .timeout_o(ifu_to)
  );

  mc_req_hold #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_lsu_hold (
    .clk      (clk),
    .rst_n    (i_rst_n),
    .start    (lsu_start),
    .ack      (i_lsu_ack),
    .req_o    (o_lsu_req),
    .done_o   (lsu_done),
    .timeout_o(lsu_to)
  );

  assign wd_expire  = (ifu_to | lsu_to) &
                      is_wait_state(state);
  assign o_ifu_addr = o_pc;

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= S_FETCH;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (1'b1)
      state[FETCH_I]: begin
        if (wd_expire) begin
          state_nx = S_HALT;
        end else if (ifu_done) begin
          state_nx = S_DECODE;
        end
      end
      state[DECODE_I]: begin
        state_nx = i_is_ebreak ? S_HALT : S_EXEC;
      end
      state[EXEC_I]: begin
        state_nx = (i_is_load | i_is_store) ?
                   S_MEM : S_WB;
      end
      state[MEM_I]: begin
        if (wd_expire) begin
          state_nx = S_HALT;
        end else if (lsu_done) begin
          state_nx = S_WB;
        end
      end
      state[WB_I]: begin
        state_nx = S_FETCH;
      end
      state[HALT_I]: begin
        state_nx = S_HALT;
      end
      default: begin
        state_nx = S_FETCH;
      end
    endcase
  end

  always_comb begin
    ifu_start = 1'b0;
    lsu_start = 1'b0;
    o_rf_wen  = 1'b0;
    o_csr_wen = 1'b0;
    o_commit  = 1'b0;
    o_halt    = 1'b0;
    unique case (1'b1)
      state[FETCH_I]: ifu_start = 1'b1;
      state[MEM_I]:   lsu_start = 1'b1;
      state[WB_I]: begin
        o_rf_wen  = i_wen;
        o_csr_wen = i_csr_wen;
        o_commit  = 1'b1;
      end
      state[HALT_I]:  o_halt = 1'b1;
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_ins <= NOP_INS;
    end else if (ifu_done) begin
      o_ins <= i_ifu_rdata;
    end
  end

  // PC only moves in WB so the datapath sees it stable.
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_pc      <= RESET_PC;
      o_instret <= '0;
    end else if (state[WB_I]) begin
      o_pc      <= i_pc_next;
      o_instret <= o_instret + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_good_trap <= 1'b0;
    end else if (wd_expire) begin
      o_good_trap <= 1'b0;
    end else if (state[DECODE_I] & i_is_ebreak) begin
      o_good_trap <= i_a0_zero;
    end
  end

`ifdef CTRL_TIMEOUT_EN
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_timeout <= 1'b0;
    end else if (wd_expire) begin
      o_timeout <= 1'b1;
    end
  end
`else
  assign o_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_mc_core_ctrl.sv
// Scoreboard bench for mc_core_ctrl.
// Watchdog section depends on CTRL_TIMEOUT_EN.
module tb_mc_core_ctrl;

  localparam int XLEN = 32;
  localparam int CNT_W = 32;
  localparam int TO = 16;
  localparam logic [31:0] RST_PC = 32'h8000_0000;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic             clk = 1'b0;
  logic             i_rst_n;
  logic             o_ifu_req;
  logic [XLEN-1:0]  o_ifu_addr;
  logic             i_ifu_ack;
  logic [31:0]      i_ifu_rdata;
  logic [31:0]      o_ins;
  logic             i_is_load;
  logic             i_is_store;
  logic             i_is_ebreak;
  logic             i_a0_zero;
  logic [XLEN-1:0]  i_pc_next;
  logic [XLEN-1:0]  o_pc;
  logic             o_lsu_req;
  logic             i_lsu_ack;
  logic             i_wen;
  logic             i_csr_wen;
  logic             o_rf_wen;
  logic             o_csr_wen;
  logic             o_commit;
  logic [CNT_W-1:0] o_instret;
  logic             o_halt;
  logic             o_good_trap;
  logic             o_timeout;

  always #5 clk = ~clk;

  assign i_pc_next = o_pc + 32'd4;

  mc_core_ctrl #(
    .XLEN          (XLEN),
    .RESET_PC      (RST_PC),
    .CNT_W         (CNT_W),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk        (clk),
    .i_rst_n    (i_rst_n),
    .o_ifu_req  (o_ifu_req),
    .o_ifu_addr (o_ifu_addr),
    .i_ifu_ack  (i_ifu_ack),
    .i_ifu_rdata(i_ifu_rdata),
    .o_ins      (o_ins),
    .i_is_load  (i_is_load),
    .i_is_store (i_is_store),
    .i_is_ebreak(i_is_ebreak),
    .i_a0_zero  (i_a0_zero),
    .i_pc_next  (i_pc_next),
    .o_pc       (o_pc),
    .o_lsu_req  (o_lsu_req),
    .i_lsu_ack  (i_lsu_ack),
    .i_wen      (i_wen),
    .i_csr_wen  (i_csr_wen),
    .o_rf_wen   (o_rf_wen),
    .o_csr_wen  (o_csr_wen),
    .o_commit   (o_commit),
    .o_instret  (o_instret),
    .o_halt     (o_halt),
    .o_good_trap(o_good_trap),
    .o_timeout  (o_timeout)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] cnt;
    logic        wen;
    logic        csr;
    int          gap;
  } exp_t;

  exp_t sbq[$];
  int checks = 0;
  int errs = 0;
  int cyc = 0;
  int commits = 0;
  int last_commit = -1;
  logic [31:0] m_pc;
  logic [31:0] m_cnt;
  int last_req_cyc;
  bit last_stable;
  bit ins_held;
  int last_lsu_cyc;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h want %0h",
               name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard on every commit.
  always @(negedge clk) begin : mon
    exp_t e;
    if (i_rst_n === 1'b1 && o_commit === 1'b1) begin
      commits++;
      if (sbq.size() == 0) begin
        checks++;
        errs++;
        $display("FAIL unexpected_commit: pc %0h",
                 o_pc);
      end else begin
        e = sbq.pop_front();
        chk("commit_pc", o_pc, e.pc);
        chk("commit_instret", o_instret, e.cnt);
        chk("commit_rf_wen", o_rf_wen, e.wen);
        chk("commit_csr_wen", o_csr_wen, e.csr);
        if (e.gap > 0)
          chk("commit_gap", cyc - last_commit, e.gap);
      end
      last_commit = cyc;
    end else if (o_rf_wen === 1'b1 ||
                 o_csr_wen === 1'b1) begin
      chk("wen_outside_wb",
          {o_rf_wen, o_csr_wen}, 2'b00);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_inputs();
    i_ifu_ack   = 1'b0;
    i_ifu_rdata = 32'h0;
    i_lsu_ack   = 1'b0;
    i_is_load   = 1'b0;
    i_is_store  = 1'b0;
    i_is_ebreak = 1'b0;
    i_a0_zero   = 1'b0;
    i_wen       = 1'b0;
    i_csr_wen   = 1'b0;
  endtask

  task automatic apply_reset();
    i_rst_n = 1'b0;
    clr_inputs();
    step();
    step();
    i_rst_n = 1'b1;
    m_pc  = RST_PC;
    m_cnt = 0;
  endtask

  task automatic fetch(input logic [31:0] word,
                       input int dly);
    int n = 0;
    logic [31:0] ins0;
    last_req_cyc = 0;
    last_stable = 1'b1;
    ins_held = 1'b1;
    while (o_ifu_req !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    if (o_ifu_req !== 1'b1) begin
      checks++;
      errs++;
      $display("FAIL fetch_wait: ifu_req %b want 1",
               o_ifu_req);
      return;
    end
    ins0 = o_ins;
    repeat (dly) begin
      if (o_ifu_req === 1'b1) last_req_cyc++;
      if (o_ifu_addr !== m_pc) last_stable = 1'b0;
      if (o_ins !== ins0) ins_held = 1'b0;
      step();
    end
    if (o_ifu_req === 1'b1) last_req_cyc++;
    if (o_ifu_addr !== m_pc) last_stable = 1'b0;
    i_ifu_ack   = 1'b1;
    i_ifu_rdata = word;
    step();
    i_ifu_ack   = 1'b0;
    i_ifu_rdata = 32'hdead_beef;
  endtask

  task automatic run_instr(input logic [31:0] word,
                           input bit ld, input bit st,
                           input bit wen, input bit csr,
                           input int fdly, input int ldly,
                           input int gap);
    exp_t e;
    i_is_load   = ld;
    i_is_store  = st;
    i_wen       = wen;
    i_csr_wen   = csr;
    i_is_ebreak = 1'b0;
    fetch(word, fdly);
    chk("ins_latched", o_ins, word);
    e.pc  = m_pc;
    e.cnt = m_cnt;
    e.wen = wen;
    e.csr = csr;
    e.gap = gap;
    step();
    step();
    if (ld || st) begin
      last_lsu_cyc = 0;
      repeat (ldly) begin
        if (o_lsu_req === 1'b1) last_lsu_cyc++;
        step();
      end
      if (o_lsu_req === 1'b1) last_lsu_cyc++;
      i_lsu_ack = 1'b1;
      step();
      i_lsu_ack = 1'b0;
    end
    sbq.push_back(e);
    m_pc  = m_pc + 32'd4;
    m_cnt = m_cnt + 1;
    step();
  endtask

  task automatic run_ebreak(input bit a0z);
    int c0;
    i_is_load   = 1'b0;
    i_is_store  = 1'b0;
    i_wen       = 1'b0;
    i_csr_wen   = 1'b0;
    i_is_ebreak = 1'b1;
    i_a0_zero   = a0z;
    fetch(32'h0010_0073, 0);
    c0 = commits;
    chk("ebreak_decode_nohalt", o_halt, 1'b0);
    step();
    chk("ebreak_halt", o_halt, 1'b1);
    chk("ebreak_good_trap", o_good_trap, a0z);
    repeat (5) step();
    chk("halt_sticky", o_halt, 1'b1);
    chk("halt_no_ifu_req", o_ifu_req, 1'b0);
    chk("halt_no_lsu_req", o_lsu_req, 1'b0);
    chk("halt_no_commit", commits, c0);
    chk("halt_pc_held", o_pc, m_pc);
    i_is_ebreak = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: sim stuck");
    $fatal(1);
  end

  initial begin
    i_rst_n = 1'b0;
    clr_inputs();
    repeat (3) step();
    chk("rst_pc", o_pc, RST_PC);
    chk("rst_ins", o_ins, NOP);
    chk("rst_instret", o_instret, 0);
    chk("rst_halt", o_halt, 1'b0);
    chk("rst_good_trap", o_good_trap, 1'b0);
    chk("rst_timeout", o_timeout, 1'b0);
    chk("rst_commit", o_commit, 1'b0);
    chk("rst_lsu_req", o_lsu_req, 1'b0);
    i_rst_n = 1'b1;
    m_pc  = RST_PC;
    m_cnt = 0;
    chk("first_ifu_req", o_ifu_req, 1'b1);
    chk("first_ifu_addr", o_ifu_addr, RST_PC);

    run_instr(32'h0010_0093, 0, 0, 1, 0, 0, 0, 0);
    run_instr(32'h0020_0113, 0, 0, 1, 0, 0, 0, 4);
    run_instr(32'h0030_0193, 0, 0, 1, 0, 0, 0, 4);
    chk("stream_pc", o_pc, 32'h8000_000C);
    chk("stream_instret", o_instret, 3);

    run_instr(32'h0040_0213, 0, 0, 1, 0, 5, 0, 0);
    chk("slow_fetch_req_cycles", last_req_cyc, 6);
    chk("slow_fetch_addr_stable", last_stable, 1'b1);
    chk("slow_fetch_ins_held", ins_held, 1'b1);

    run_instr(32'h0000_a283, 1, 0, 1, 0, 0, 2, 0);
    chk("load_lsu_req_cycles", last_lsu_cyc, 3);

    run_instr(32'h3402_9073, 0, 0, 0, 1, 0, 0, 0);
    run_instr(32'h0050_a023, 0, 1, 0, 0, 0, 0, 5);
    chk("store_lsu_req_cycles", last_lsu_cyc, 1);
    chk("pre_rst_instret", o_instret, m_cnt);
    chk("pre_rst_pc", o_pc, m_pc);

    i_is_load = 1'b1;
    i_wen     = 1'b1;
    fetch(32'h0040_a303, 0);
    step();
    step();
    chk("mem_lsu_req", o_lsu_req, 1'b1);
    step();
    #2;
    i_rst_n = 1'b0;
    #1;
    chk("async_rst_lsu_req", o_lsu_req, 1'b0);
    chk("async_rst_pc", o_pc, RST_PC);
    chk("async_rst_instret", o_instret, 0);
    chk("async_rst_ins", o_ins, NOP);
    clr_inputs();
    step();
    i_rst_n = 1'b1;
    m_pc  = RST_PC;
    m_cnt = 0;
    chk("restart_ifu_req", o_ifu_req, 1'b1);
    run_instr(32'h0010_0513, 0, 0, 1, 0, 0, 0, 0);
    chk("restart_instret", o_instret, 1);

    run_ebreak(1'b1);
    apply_reset();
    chk("halt_cleared", o_halt, 1'b0);
    run_ebreak(1'b0);

    apply_reset();
`ifdef CTRL_TIMEOUT_EN
    begin
      int rc = 0;
      int n = 0;
      while (o_ifu_req === 1'b1 && n < 40) begin
        rc++;
        step();
        n++;
      end
      chk("wd_req_cycles", rc, TO);
      chk("wd_timeout", o_timeout, 1'b1);
      chk("wd_halt", o_halt, 1'b1);
      chk("wd_good_trap", o_good_trap, 1'b0);
    end
`else
    repeat (100) step();
    chk("nowd_ifu_req", o_ifu_req, 1'b1);
    chk("nowd_halt", o_halt, 1'b0);
    chk("nowd_timeout", o_timeout, 1'b0);
`endif
    chk("sb_drained", sbq.size(), 0);

    $display("Result: errors=%0d of %0d checks",
             errs, checks);
    $finish;
  end

endmodule
